operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 9, giving the operand width in bits, which matches the adder operand width.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port sw, input, WIDTH bits, the operand value to capture.
REQ-005 SHALL have port load, input, 1 bit, a level-sensitive capture request that may be held many cycles.
REQ-006 SHALL have port clear, input, 1 bit, a synchronous discard of both operands.
REQ-007 SHALL have port a, output, WIDTH bits, the registered first operand to the adder.
REQ-008 SHALL have port b, output, WIDTH bits, the registered second operand to the adder.
REQ-009 SHALL have port valid, output, 1 bit, high when a and b form a complete pair.
REQ-010 SHALL have port phase, output, 2 bits, the current state: 00 LOAD_A, 01 LOAD_B, 10 READY; 11 is never driven.

Function
REQ-011 SHALL detect a load event as load=1 at a rising clk edge where the internal registered copy load_q=0; load_q updates to load every edge.
REQ-012 SHALL produce exactly one load event per low-to-high load transition, regardless of how long load stays high.
REQ-013 SHALL implement a three-state FSM: LOAD_A, LOAD_B, READY.
REQ-014 SHALL, in LOAD_A on a load event, capture sw into a and move to LOAD_B, leaving b unchanged.
REQ-015 SHALL, in LOAD_B on a load event, capture sw into b and move to READY.
REQ-016 SHALL, in READY on a load event, capture sw into a, leave b unchanged, and move to LOAD_B.
REQ-017 SHALL hold state, a and b when there is no load event.
REQ-018 SHALL make a captured value visible on a or b immediately after the edge at which the load event is detected (one-cycle latency from load first sampled high).
REQ-019 SHALL drive valid = (phase==READY), registered with no combinational path from any input.
REQ-020 SHALL, on clear=1 at an edge, set a=0, b=0, state LOAD_A and valid=0, while still updating load_q.
REQ-021 SHALL give clear priority over a simultaneous load event, so that no capture occurs.
REQ-022 SHALL capture sw exactly as sampled, with no saturation or modification; all-ones (e.g. 9'h1FF) is legal.

Reset
REQ-023 SHALL, on reset=1 at an edge, set a=0, b=0, state LOAD_A, phase=00 and valid=0, with reset taking priority over clear and load.
REQ-024 SHALL set load_q=1 on reset, so that a load held high through reset produces no event until it falls and rises again.
REQ-025 SHALL abandon any partial pair when reset arrives mid-operation, e.g. in LOAD_B with a already captured, and return to the REQ-023 values.

Verification
REQ-026 SHALL pass this scenario: reset, then sw=9'h000 with a load pulse, then sw=9'h001 with a load pulse -> a=000, b=001, valid=1, phase=10.
REQ-027 SHALL pass this scenario: load held high for 20 cycles in LOAD_A with sw=9'h1FE -> a=1FE, exactly one transition to LOAD_B, b unchanged.
REQ-028 SHALL pass this scenario: in READY with a=1FE and b=001, sw=9'h1FF and a load pulse -> a=1FF, b=001, valid=0, phase=01.
REQ-029 SHALL pass this scenario: clear and load rising together in LOAD_B -> a=0, b=0, phase=00, and no capture.
REQ-030 SHALL pass this scenario: load high before and throughout reset, deasserted 3 cycles after reset -> no capture until the next rising edge of load.
REQ-031 SHALL pass this scenario: reset asserted in LOAD_B with a=0AA -> the next cycle shows a=0, b=0, valid=0, phase=00.

Source files
------------

// File: rtl/operand_loader.sv
// ============================================================================
// Module      : operand_loader
// Description : Captures two adder operands from sw on rising edges of load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic [1:0]       phase
);

  localparam logic [1:0] c_LOAD_A = 2'b00;
  localparam logic [1:0] c_LOAD_B = 2'b01;
  localparam logic [1:0] c_READY  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  logic             load_q;
  logic             w_load_evt;

  assign w_load_evt = load & ~load_q;

  // load_q resets high so a load held through reset needs a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      load_q  <= load;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (clear) begin
      state_d = c_LOAD_A;
      a_d     = '0;
      b_d     = '0;
    end else if (w_load_evt) begin
      case (state_q)
        c_LOAD_A: begin
          a_d     = sw;
          state_d = c_LOAD_B;
        end
        c_LOAD_B: begin
          b_d     = sw;
          state_d = c_READY;
        end
        c_READY: begin
          a_d     = sw;
          state_d = c_LOAD_B;
        end
        default: state_d = c_LOAD_A;
      endcase
    end
    valid_d = (state_d == c_READY);
  end

  always_comb begin
    a     = a_q;
    b     = b_q;
    valid = valid_q;
    phase = state_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module      : tb_operand_loader
// Description : Directed self-checking bench for operand_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_loader;

  logic       clk;
  logic       reset;
  logic [8:0] sw;
  logic       load;
  logic       clear;
  logic [8:0] a;
  logic [8:0] b;
  logic       valid;
  logic [1:0] phase;

  int total = 0;
  int bad   = 0;

  operand_loader #(.WIDTH(9)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .load  (load),
    .clear (clear),
    .a     (a),
    .b     (b),
    .valid (valid),
    .phase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [8:0] ea, input logic [8:0] eb,
                         input logic ev, input logic [1:0] ep);
    chk({tag, ".a"}, a, ea);
    chk({tag, ".b"}, b, eb);
    chk({tag, ".valid"}, {8'd0, valid}, {8'd0, ev});
    chk({tag, ".phase"}, {7'd0, phase}, {7'd0, ep});
  endtask

  task automatic pulse(input logic [8:0] v);
    sw   = v;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; clear = 1'b0; sw = '0;
    step();
    step();
    chk_all("reset", 9'h000, 9'h000, 1'b0, 2'b00);
    reset = 1'b0;
    step();

    // Basic pair capture, including one-cycle latency on a.
    sw = 9'h000; load = 1'b1;
    step();
    chk_all("latA", 9'h000, 9'h000, 1'b0, 2'b01);
    load = 1'b0;
    step();
    pulse(9'h001);
    chk_all("pair1", 9'h000, 9'h001, 1'b1, 2'b10);

    // Clear from READY, then hold load high for 20 cycles.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_all("clrRdy", 9'h000, 9'h000, 1'b0, 2'b00);
    sw = 9'h1FE; load = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk_all("hold20", 9'h1FE, 9'h000, 1'b0, 2'b01);
    load = 1'b0;
    step();
    pulse(9'h001);
    chk_all("pair2", 9'h1FE, 9'h001, 1'b1, 2'b10);

    // Reload from READY with all-ones.
    pulse(9'h1FF);
    chk_all("reload", 9'h1FF, 9'h001, 1'b0, 2'b01);

    // Clear wins over a simultaneous load rise in LOAD_B.
    sw = 9'h055; clear = 1'b1; load = 1'b1;
    step();
    clear = 1'b0;
    chk_all("clrLd", 9'h000, 9'h000, 1'b0, 2'b00);
    step();
    chk_all("clrLdHeld", 9'h000, 9'h000, 1'b0, 2'b00);
    load = 1'b0;
    step();

    // Reset mid-pair abandons the partial operand.
    pulse(9'h0AA);
    chk_all("partial", 9'h0AA, 9'h000, 1'b0, 2'b01);
    reset = 1'b1; load = 1'b1; sw = 9'h123;
    step();
    chk_all("rstMid", 9'h000, 9'h000, 1'b0, 2'b00);
    step();

    // Load held through reset then for 3 more cycles: no capture until a new rise.
    reset = 1'b0;
    step(); step(); step();
    chk_all("ldThruRst", 9'h000, 9'h000, 1'b0, 2'b00);
    load = 1'b0;
    step();
    chk_all("ldFall", 9'h000, 9'h000, 1'b0, 2'b00);
    load = 1'b1;
    step();
    chk_all("ldRise", 9'h123, 9'h000, 1'b0, 2'b01);
    load = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
